tx_pcs_scrambler: RTL and testbench

- TX PCS stage directly upstream of the 66:64 TX gearbox in the GTH no-buffer/no-gearbox path.
- Accepts complete 64b/66b blocks (2-bit sync header + 64-bit payload) from the encoder.
- Applies the self-synchronising x^58+x^39+1 scrambler to the payload.
- Emits each block as two 32-bit words with header and sequence counter, in the format the gearbox consumes. Generates the 33-slot sequence pause that makes 32 blocks fill 33 block-times.

---
 rtl/tx_pcs_scrambler.sv | 96 +++++++++
 tb/tb_tx_pcs_scrambler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_pcs_scrambler.sv
// TX PCS scrambler: takes 64b/66b blocks, scrambles the payload with x^58+x^39+1,
// and emits two 32-bit words per block with header and gearbox sequence count.
module tx_pcs_scrambler #(
  parameter logic [57:0] SCR_INIT   = 58'h3FF_FFFF_FFFF_FFFF,
  parameter bit          SCR_BYPASS = 1'b0,
  parameter logic [63:0] IDLE_BLOCK = 64'h0000_0000_0000_001E
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] blk_data_i,
  input  logic [1:0]  blk_head_i,
  input  logic        blk_valid_i,
  output logic        blk_ready_o,
  output logic [31:0] data_o,
  output logic [5:0]  head_o,
  output logic [6:0]  sequence_o,
  output logic        underrun_o,
  output logic        hdr_err_o
);

  logic        ph_q;
  logic [5:0]  seq_q;
  logic [57:0] scr_q, scr_d;
  logic [31:0] hi_q;
  logic [31:0] data_q, data_d;
  logic [1:0]  head_q;
  logic [6:0]  sequence_q;
  logic        underrun_q, hdr_err_q;

  logic [63:0] blk_sel;
  logic [1:0]  head_sel;
  logic [31:0] scr_in, scr_out;
  logic        pause, word_active;

  // Serial LSB-first scrambler, 32 steps unrolled; returns {next_state, data}.
  function automatic logic [89:0] scr32(input logic [31:0] din, input logic [57:0] s_in);
    logic [57:0] s;
    logic [31:0] dout;
    logic        b;
    s = s_in;
    dout = '0;
    for (int i = 0; i < 32; i++) begin
      b = din[i] ^ s[38] ^ s[57];
      dout[i] = b;
      s = {s[56:0], b};
    end
    return {s, dout};
  endfunction

  always_comb begin
    pause       = (seq_q == 6'd32);
    blk_ready_o = !ph_q && !pause;
    word_active = !pause;
    blk_sel     = blk_valid_i ? blk_data_i : IDLE_BLOCK;
    head_sel    = blk_valid_i ? blk_head_i : 2'b10;
    scr_in      = ph_q ? hi_q : blk_sel[31:0];
    {scr_d, scr_out} = scr32(scr_in, scr_q);
    data_d      = SCR_BYPASS ? scr_in : scr_out;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ph_q       <= 1'b0;
      seq_q      <= '0;
      scr_q      <= SCR_INIT;
      hi_q       <= '0;
      data_q     <= '0;
      head_q     <= '0;
      sequence_q <= '0;
      underrun_q <= 1'b0;
      hdr_err_q  <= 1'b0;
    end else begin
      ph_q       <= !ph_q;
      if (ph_q) seq_q <= pause ? 6'd0 : seq_q + 6'd1;
      sequence_q <= {1'b0, seq_q};
      underrun_q <= blk_ready_o && !blk_valid_i;
      hdr_err_q  <= blk_ready_o && blk_valid_i && (blk_head_i[0] == blk_head_i[1]);
      // Pause slot leaves data, header and scrambler state untouched.
      if (word_active) begin
        data_q <= data_d;
        if (!SCR_BYPASS) scr_q <= scr_d;
      end
      if (blk_ready_o) begin
        hi_q   <= blk_sel[63:32];
        head_q <= head_sel;
      end
    end
  end

  assign data_o     = data_q;
  assign head_o     = {4'b0000, head_q};
  assign sequence_o = sequence_q;
  assign underrun_o = underrun_q;
  assign hdr_err_o  = hdr_err_q;

endmodule

// File: tb/tb_tx_pcs_scrambler.sv
// Bench for tx_pcs_scrambler: hand vectors plus a bit-serial reference scrambler
// scoreboard, run on a scrambling instance and a bypass instance in parallel.
module tb_tx_pcs_scrambler;

  localparam logic [57:0] INIT = 58'h3FF_FFFF_FFFF_FFFF;
  localparam logic [63:0] IDLE = 64'h0000_0000_0000_001E;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] d_s = '0, d_b = '0;
  logic [1:0]  head = 2'b01;
  logic        valid = 1'b0;

  logic        rdy_s, rdy_b, und_s, und_b, herr_s, herr_b;
  logic [31:0] dat_s, dat_b;
  logic [5:0]  hd_s, hd_b;
  logic [6:0]  seq_s, seq_b;

  tx_pcs_scrambler #(.SCR_BYPASS(1'b0)) dut_s (
    .clk_i(clk), .rst_i(rst), .blk_data_i(d_s), .blk_head_i(head), .blk_valid_i(valid),
    .blk_ready_o(rdy_s), .data_o(dat_s), .head_o(hd_s), .sequence_o(seq_s),
    .underrun_o(und_s), .hdr_err_o(herr_s));

  tx_pcs_scrambler #(.SCR_BYPASS(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst), .blk_data_i(d_b), .blk_head_i(head), .blk_valid_i(valid),
    .blk_ready_o(rdy_b), .data_o(dat_b), .head_o(hd_b), .sequence_o(seq_b),
    .underrun_o(und_b), .hdr_err_o(herr_b));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  h;
    logic [63:0] d;
    logic        e_rdy;
    logic [6:0]  e_seq;
    logic        chk_s;
    logic [31:0] e_ds;
    logic [31:0] e_db;
    logic [5:0]  e_hd;
    logic        e_und;
    logic        e_herr;
  } vec_t;

  vec_t tbl[6];

  // Scoreboard state
  int          n;
  logic [57:0] ms;
  logic [31:0] e_ds, e_db, hi_s, hi_b;
  logic [5:0]  e_hd;
  logic [63:0] cur_s, cur_b;
  logic [1:0]  cur_head;
  int          blk_idx, blocks_out, und_exp, und_seen;
  bit          rand_hdr;

  function automatic logic [1:0] pick_head(input bit r);
    int k;
    if (!r) return 2'b01;
    k = $urandom_range(0, 9);
    if (k == 0) return 2'b11;
    if (k == 1) return 2'b00;
    return (k % 2) ? 2'b01 : 2'b10;
  endfunction

  task automatic model_reset();
    n = 0; ms = INIT;
    e_ds = '0; e_db = '0; hi_s = '0; hi_b = '0; e_hd = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data_s"}, dat_s, 0);  chk({tag, "_data_b"}, dat_b, 0);
    chk({tag, "_head"}, hd_s, 0);     chk({tag, "_seq"}, seq_s, 0);
    chk({tag, "_und"}, und_s, 0);     chk({tag, "_herr"}, herr_s, 0);
    chk({tag, "_ready"}, rdy_s, 1);
  endtask

  task automatic run_cycle(input bit v);
    int p;
    bit acc, e_und, e_herr;
    logic [63:0] ws, wb, rs;
    logic [1:0]  h;
    logic        b;
    p = n % 66;
    acc = (p % 2 == 0) && (p < 64);
    chk("ready_s", rdy_s, acc);
    chk("ready_b", rdy_b, acc);
    valid = v; head = cur_head; d_s = cur_s; d_b = cur_b;
    @(posedge clk); #1;
    e_und = 1'b0; e_herr = 1'b0;
    if (acc) begin
      if (v) begin ws = cur_s; wb = cur_b; h = cur_head; end
      else   begin ws = IDLE;  wb = IDLE;  h = 2'b10;    end
      rs = '0;
      for (int i = 0; i < 64; i++) begin
        b = ws[i] ^ ms[38] ^ ms[57];
        rs[i] = b;
        ms = {ms[56:0], b};
      end
      e_ds = rs[31:0]; hi_s = rs[63:32];
      e_db = wb[31:0]; hi_b = wb[63:32];
      e_hd = {4'b0, h};
      e_und = !v;
      e_herr = v && (h == 2'b00 || h == 2'b11);
      if (v) begin
        blk_idx++;
        cur_b = 64'(blk_idx);
        cur_s = {$urandom, $urandom};
        cur_head = pick_head(rand_hdr);
      end else und_exp++;
    end else if (p < 64) begin
      e_ds = hi_s; e_db = hi_b;
      blocks_out++;
    end
    chk("data_s", dat_s, e_ds);
    chk("data_b", dat_b, e_db);
    chk("head_s", hd_s, e_hd);
    chk("head_b", hd_b, e_hd);
    chk("seq_s", seq_s, 64'(p / 2));
    chk("seq_b", seq_b, 64'(p / 2));
    chk("underrun", und_s, e_und);
    chk("hdr_err", herr_s, e_herr);
    if (und_s) und_seen++;
    n++;
  endtask

  initial begin
    // Hand vectors from a fresh reset: zero block scrambles to 0 / 03FFFF80.
    tbl[0] = '{1'b1, 2'b01, 64'h0,                    1'b1, 7'd0, 1'b1, 32'h0,        32'h0,        6'h01, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 2'b11, 64'hDEAD_BEEF_DEAD_BEEF,  1'b0, 7'd0, 1'b1, 32'h03FFFF80, 32'h0,        6'h01, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 2'b11, 64'hDEAD_BEEF_1234_5678,  1'b1, 7'd1, 1'b0, 32'h0,        32'h0000001E, 6'h02, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 2'b01, 64'h0,                    1'b0, 7'd1, 1'b0, 32'h0,        32'h0,        6'h02, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 2'b11, 64'h0123_4567_89AB_CDEF,  1'b1, 7'd2, 1'b0, 32'h0,        32'h89ABCDEF, 6'h03, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 2'b01, 64'h0,                    1'b0, 7'd2, 1'b0, 32'h0,        32'h01234567, 6'h03, 1'b0, 1'b0};

    blk_idx = 0; blocks_out = 0; und_exp = 0; und_seen = 0; rand_hdr = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_zero("rst0");
    #2 rst = 1'b0;

    foreach (tbl[k]) begin
      chk($sformatf("tbl%0d_ready", k), rdy_b, tbl[k].e_rdy);
      valid = tbl[k].v; head = tbl[k].h; d_s = tbl[k].d; d_b = tbl[k].d;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_seq", k), seq_b, tbl[k].e_seq);
      chk($sformatf("tbl%0d_data_b", k), dat_b, tbl[k].e_db);
      if (tbl[k].chk_s) chk($sformatf("tbl%0d_data_s", k), dat_s, tbl[k].e_ds);
      chk($sformatf("tbl%0d_head", k), hd_b, tbl[k].e_hd);
      chk($sformatf("tbl%0d_und", k), und_b, tbl[k].e_und);
      chk($sformatf("tbl%0d_herr", k), herr_b, tbl[k].e_herr);
    end

    // Fresh start for the scoreboard phases.
    #2 rst = 1'b1;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    model_reset();
    cur_b = 64'd0; cur_s = {$urandom, $urandom}; cur_head = 2'b01;

    // Continuous valid stream, >1000 blocks.
    repeat (2100) run_cycle(1'b1);
    chk("blocks_1000", 64'(blk_idx >= 1000), 1);

    // Random valid with occasional bad headers.
    rand_hdr = 1'b1;
    repeat (700) run_cycle($urandom_range(0, 3) != 0);

    // Stop right after the high-word edge of slot 17, then reset mid-block.
    rand_hdr = 1'b0;
    while (n % 66 != 36) run_cycle(1'b1);
    #2 rst = 1'b1;
    #1 chk_zero("rst_mid");
    @(posedge clk); #1;
    chk_zero("rst_hold");
    #2 rst = 1'b0;
    model_reset();
    repeat (200) run_cycle(1'b1);

    chk("underrun_count", 64'(und_seen), 64'(und_exp));
    chk("blocks_emitted", 64'(blocks_out > 1000), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
